dual_channel_fifo_scheduler: RTL and testbench

- Sequences a shared FIFO that is loaded from two source channels (CH1, CH2) and then drained.
- On start, arbitrates between pending channel requests with round-robin on ties.
- Steers the channel mux and gates FIFO writes for one burst of up to BURST_LEN words, then drains the FIFO until empty.
- Sits between the channel sources and the FIFO. It is the only driver of the FIFO read/write strobes and of the mux select.

---
 rtl/dual_channel_fifo_scheduler_if.sv | 31 +++
 rtl/dual_channel_fifo_scheduler.sv | 103 ++++++++++
 tb/tb_dual_channel_fifo_scheduler.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/dual_channel_fifo_scheduler_if.sv
// Channel/FIFO handshake bundle for the dual-channel FIFO scheduler.
// master = scheduler side, slave = channel sources, FIFO and controller side.
interface dual_channel_fifo_scheduler_if #(
    parameter int unsigned CNT_W = 4
);
    logic             start;
    logic             req_ch1;
    logic             req_ch2;
    logic             valid_ch1;
    logic             valid_ch2;
    logic             full;
    logic             empty;
    logic             mux;
    logic             write;
    logic             read;
    logic             ready;
    logic             grant_ch1;
    logic             grant_ch2;
    logic             done;
    logic [CNT_W-1:0] word_cnt;

    modport master (
        input  start, req_ch1, req_ch2, valid_ch1, valid_ch2, full, empty,
        output mux, write, read, ready, grant_ch1, grant_ch2, done, word_cnt
    );

    modport slave (
        output start, req_ch1, req_ch2, valid_ch1, valid_ch2, full, empty,
        input  mux, write, read, ready, grant_ch1, grant_ch2, done, word_cnt
    );
endinterface

// File: rtl/dual_channel_fifo_scheduler.sv
// Arbitrates two channels onto a shared FIFO: one burst of up to BURST_LEN words
// from the granted channel, then drains the FIFO until it reports empty.
module dual_channel_fifo_scheduler #(
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned CNT_W     = 4
) (
    input logic                          clk,
    input logic                          reset,
    dual_channel_fifo_scheduler_if.master bus
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StArb      = 3'd1,
        StLoadCh1  = 3'd2,
        StLoadCh2  = 3'd3,
        StFinish   = 3'd4,
        StReadFifo = 3'd5
    } state_e;

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(BURST_LEN - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // 1 = CH1 was granted last; resets to CH2 so CH1 wins the first tie.
    logic             last_ch1_q, last_ch1_d;
    logic             load_valid;
    logic             load_write;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            last_ch1_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_ch1_q <= last_ch1_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_ch1_d    = last_ch1_q;
        load_valid    = 1'b0;
        load_write    = 1'b0;
        bus.mux       = 1'b0;
        bus.write     = 1'b0;
        bus.read      = 1'b0;
        bus.ready     = 1'b0;
        bus.grant_ch1 = 1'b0;
        bus.grant_ch2 = 1'b0;
        bus.done      = 1'b0;
        bus.word_cnt  = cnt_q;

        case (state_q)
            StIdle: begin
                bus.ready = 1'b1;
                if (bus.start) state_d = StArb;
            end
            StArb: begin
                if (bus.req_ch1 && (!bus.req_ch2 || !last_ch1_q)) begin
                    state_d    = StLoadCh1;
                    last_ch1_d = 1'b1;
                end else if (bus.req_ch2) begin
                    state_d    = StLoadCh2;
                    last_ch1_d = 1'b0;
                end
            end
            StLoadCh1, StLoadCh2: begin
                if (state_q == StLoadCh1) begin
                    bus.mux       = 1'b1;
                    bus.grant_ch1 = 1'b1;
                    load_valid    = bus.valid_ch1;
                end else begin
                    bus.grant_ch2 = 1'b1;
                    load_valid    = bus.valid_ch2;
                end
                // full takes priority over a coincident final word
                load_write = load_valid && !bus.full;
                bus.write  = load_write;
                if (bus.full) begin
                    state_d = StFinish;
                end else if (load_write) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastCnt) state_d = StFinish;
                end
            end
            StFinish: begin
                bus.done = 1'b1;
                cnt_d    = '0;
                state_d  = StReadFifo;
            end
            StReadFifo: begin
                bus.read = !bus.empty;
                if (bus.empty) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_dual_channel_fifo_scheduler.sv
// Directed self-checking bench for dual_channel_fifo_scheduler (BURST_LEN=8, CNT_W=4).
module tb_dual_channel_fifo_scheduler;

    localparam int unsigned CNT_W     = 4;
    localparam int unsigned BURST_LEN = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    dual_channel_fifo_scheduler_if #(.CNT_W(CNT_W)) bus ();

    dual_channel_fifo_scheduler #(
        .BURST_LEN(BURST_LEN),
        .CNT_W    (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            check("excl_wr_rd", 32'(bus.write & bus.read), 32'd0);
            check("excl_grants", 32'(bus.grant_ch1 & bus.grant_ch2), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // IDLE -> ARB -> LOAD; returns settled in the first LOAD cycle.
    task automatic start_seq(input logic r1, input logic r2, input logic keep_start);
        bus.start   = 1'b1;
        bus.req_ch1 = r1;
        bus.req_ch2 = r2;
        #1;
        check("idle_ready", 32'(bus.ready), 32'd1);
        tick();
        bus.start = keep_start;
        #1;
        check("arb_ready", 32'(bus.ready), 32'd0);
        check("arb_write", 32'(bus.write), 32'd0);
        tick();
        bus.req_ch1 = 1'b0;
        bus.req_ch2 = 1'b0;
        #1;
    endtask

    task automatic wait_done(input string tag, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (bus.done) break;
            tick();
        end
        check(tag, 32'(bus.done), 32'd1);
    endtask

    // Called settled in the first READ_FIFO cycle; ends settled back in IDLE.
    task automatic drain(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            bus.empty = 1'b0;
            #1;
            check({tag, "_read"}, 32'(bus.read), 32'd1);
            tick();
        end
        bus.empty = 1'b1;
        #1;
        check({tag, "_read_empty"}, 32'(bus.read), 32'd0);
        tick();
        check({tag, "_ready_end"}, 32'(bus.ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [10:0] pat;
        logic        exp_g1;
        bus.start = 0; bus.req_ch1 = 0; bus.req_ch2 = 0;
        bus.valid_ch1 = 0; bus.valid_ch2 = 0; bus.full = 0; bus.empty = 1;

        // reset state
        #2;
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_outs", {25'd0, bus.mux, bus.write, bus.read, bus.grant_ch1, bus.grant_ch2,
              bus.done, 1'b0}, 32'd0);
        check("rst_cnt", 32'(bus.word_cnt), 32'd0);
        tick();
        reset = 1'b1;
        #1;

        // 1: full CH1 burst, 8 writes, 8 reads
        bus.valid_ch1 = 1'b1;
        start_seq(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check("t1_mux", 32'(bus.mux), 32'd1);
            check("t1_g1", 32'(bus.grant_ch1), 32'd1);
            check("t1_write", 32'(bus.write), 32'd1);
            check("t1_cnt", 32'(bus.word_cnt), 32'(i));
            tick();
        end
        check("t1_done", 32'(bus.done), 32'd1);
        check("t1_final_cnt", 32'(bus.word_cnt), 32'd8);
        check("t1_fin_write", 32'(bus.write), 32'd0);
        bus.valid_ch1 = 1'b0;
        tick();
        check("t1_done_pulse", 32'(bus.done), 32'd0);
        check("t1_cnt_clear", 32'(bus.word_cnt), 32'd0);
        drain("t1", 8);

        // 2: round-robin ties from reset: CH1, CH2, CH1
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_g1 = (k != 1);
            bus.valid_ch1 = 1'b1;
            bus.valid_ch2 = 1'b1;
            start_seq(1'b1, 1'b1, 1'b0);
            check("t2_g1", 32'(bus.grant_ch1), 32'(exp_g1));
            check("t2_g2", 32'(bus.grant_ch2), 32'(!exp_g1));
            wait_done("t2_done", 20);
            check("t2_cnt", 32'(bus.word_cnt), 32'd8);
            bus.valid_ch1 = 1'b0;
            bus.valid_ch2 = 1'b0;
            tick();
            drain("t2", 0);
        end

        // 3: CH2 with valid gaps
        pat = 11'b11111011001;
        start_seq(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) begin
            bus.valid_ch2 = pat[i];
            #1;
            check("t3_write", 32'(bus.write), 32'(pat[i]));
            check("t3_g2", 32'(bus.grant_ch2), 32'd1);
            check("t3_mux", 32'(bus.mux), 32'd0);
            tick();
        end
        bus.valid_ch2 = 1'b0;
        check("t3_done", 32'(bus.done), 32'd1);
        check("t3_cnt", 32'(bus.word_cnt), 32'd8);
        tick();
        drain("t3", 1);

        // 4: full truncates CH1 burst after 5 writes
        bus.valid_ch1 = 1'b1;
        start_seq(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("t4_write", 32'(bus.write), 32'd1);
            tick();
        end
        bus.full = 1'b1;
        #1;
        check("t4_full_write", 32'(bus.write), 32'd0);
        check("t4_full_g1", 32'(bus.grant_ch1), 32'd1);
        check("t4_full_done", 32'(bus.done), 32'd0);
        tick();
        check("t4_done", 32'(bus.done), 32'd1);
        check("t4_cnt", 32'(bus.word_cnt), 32'd5);
        bus.full = 1'b0;
        bus.valid_ch1 = 1'b0;
        tick();
        drain("t4", 2);

        // 5: reset during CH2 load after 3 writes
        bus.valid_ch2 = 1'b1;
        start_seq(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("t5_write", 32'(bus.write), 32'd1);
            tick();
        end
        reset = 1'b0;
        #1;
        check("t5_rst_write", 32'(bus.write), 32'd0);
        check("t5_rst_g2", 32'(bus.grant_ch2), 32'd0);
        check("t5_rst_ready", 32'(bus.ready), 32'd1);
        check("t5_rst_cnt", 32'(bus.word_cnt), 32'd0);
        tick();
        reset = 1'b1;
        bus.valid_ch2 = 1'b0;
        #1;
        start_seq(1'b1, 1'b1, 1'b0);
        check("t5_tie_g1", 32'(bus.grant_ch1), 32'd1);
        bus.valid_ch1 = 1'b1;
        wait_done("t5_done", 20);
        check("t5_cnt", 32'(bus.word_cnt), 32'd8);
        bus.valid_ch1 = 1'b0;
        tick();
        drain("t5", 0);

        // 6: start held through LOAD and READ_FIFO is ignored
        bus.valid_ch1 = 1'b1;
        start_seq(1'b1, 1'b0, 1'b1);
        wait_done("t6_done", 20);
        check("t6_cnt", 32'(bus.word_cnt), 32'd8);
        bus.valid_ch1 = 1'b0;
        tick();
        drain("t6", 2);
        bus.start = 1'b0;
        tick();
        check("t6_still_idle", 32'(bus.ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
